// File: rtl/wb_cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_cmd_pkg: opcodes, status bytes and FSM states for wb_cmd_initiator |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package wb_cmd_pkg;

  localparam logic [7:0] OP_WRITE   = 8'h57;
  localparam logic [7:0] OP_READ    = 8'h52;
  localparam logic [7:0] OP_NOP     = 8'h4E;

  localparam logic [7:0] ST_OK      = 8'h4B;
  localparam logic [7:0] ST_TIMEOUT = 8'h54;
  localparam logic [7:0] ST_BADOP   = 8'h3F;

  localparam logic [3:0] SEL_ALL    = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_DATA     = 3'd2,
    S_BUS      = 3'd3,
    S_RSP_STAT = 3'd4,
    S_RSP_DATA = 3'd5
  } wb_cmd_state_t;

  // Opcodes that carry an address and end in a Wishbone cycle
  function automatic logic is_bus_op(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_rsp_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_rsp_serializer: emits a status byte plus optional 32-bit word MSB  |
// | first on a valid/ready byte stream. Revision: 1.0                    |
// +----------------------------------------------------------------------+
module wb_rsp_serializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [7:0]  i_status,
  input  logic [31:0] i_word,
  input  logic        i_has_word,
  output logic [7:0]  o_rsp_data,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic        o_done
);

  logic [39:0] r_buf;
  logic [2:0]  r_left;
  logic        w_fire;

  assign o_rsp_valid = (r_left != 3'd0);
  assign o_rsp_data  = r_buf[39:32];
  assign w_fire      = o_rsp_valid && i_rsp_ready;
  assign o_done      = w_fire && (r_left == 3'd1);

  // Shifting in zeros keeps rsp_data at 0 once the stream drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf  <= 40'h0;
      r_left <= 3'd0;
    end else if (i_load) begin
      r_buf  <= {i_status, (i_has_word ? i_word : 32'h0)};
      r_left <= i_has_word ? 3'd5 : 3'd1;
    end else if (w_fire) begin
      r_buf  <= {r_buf[31:0], 8'h00};
      r_left <= r_left - 3'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_cmd_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_cmd_initiator: byte-stream command parser driving single Wishbone  |
// | classic cycles as bus initiator. Revision: 1.0                       |
// +----------------------------------------------------------------------+
module wb_cmd_initiator
  import wb_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy
);

  localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  wb_cmd_state_t r_state;
  wb_cmd_state_t w_next_state;

  logic [1:0]  r_byte_cnt;
  logic        r_is_write;
  logic [31:0] r_adr;
  logic [23:0] r_dat;
  logic [15:0] r_tmo_cnt;

  logic        w_cmd_fire;
  logic        w_last_byte;
  logic        w_tmo_hit;
  logic        w_bus_done;
  logic        w_rsp_fire;
  logic        w_rsp_done;

  logic        w_ld;
  logic [7:0]  w_ld_status;
  logic [31:0] w_ld_word;
  logic        w_ld_has_word;

  assign cmd_ready   = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_DATA);
  assign busy        = (r_state != S_IDLE);
  assign w_cmd_fire  = cmd_valid && cmd_ready;
  assign w_last_byte = w_cmd_fire && (r_byte_cnt == 2'd3);
  assign w_tmo_hit   = (r_tmo_cnt == c_TMO_LAST);
  // Ack takes priority; a timeout only matters when no ack arrives
  assign w_bus_done  = (r_state == S_BUS) && (wbm_ack_i || w_tmo_hit);
  assign w_rsp_fire  = rsp_valid && rsp_ready;

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (w_cmd_fire) w_next_state = is_bus_op(cmd_data) ? S_ADDR : S_RSP_STAT;
      S_ADDR:     if (w_last_byte) w_next_state = r_is_write ? S_DATA : S_BUS;
      S_DATA:     if (w_last_byte) w_next_state = S_BUS;
      S_BUS:      if (w_bus_done) w_next_state = S_RSP_STAT;
      S_RSP_STAT: begin
        if (w_rsp_done)      w_next_state = S_IDLE;
        else if (w_rsp_fire) w_next_state = S_RSP_DATA;
      end
      S_RSP_DATA: if (w_rsp_done) w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_ld          = 1'b0;
    w_ld_status   = ST_OK;
    w_ld_word     = 32'h0;
    w_ld_has_word = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire && !is_bus_op(cmd_data)) begin
          w_ld        = 1'b1;
          w_ld_status = (cmd_data == OP_NOP) ? ST_OK : ST_BADOP;
        end
      end
      S_BUS: begin
        if (wbm_ack_i) begin
          w_ld          = 1'b1;
          w_ld_word     = wbm_dat_i;
          w_ld_has_word = !r_is_write;
        end else if (w_tmo_hit) begin
          w_ld        = 1'b1;
          w_ld_status = ST_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= 2'd0;
      r_is_write <= 1'b0;
      r_adr      <= 32'h0;
      r_dat      <= 24'h0;
      r_tmo_cnt  <= 16'h0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_sel_o  <= 4'h0;
      wbm_adr_o  <= 32'h0;
      wbm_dat_o  <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_is_write <= (cmd_data == OP_WRITE);
            r_byte_cnt <= 2'd0;
          end
        end
        S_ADDR: begin
          if (w_cmd_fire) begin
            r_adr      <= {r_adr[23:0], cmd_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_last_byte && !r_is_write) begin
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_we_o  <= 1'b0;
              wbm_sel_o <= SEL_ALL;
              wbm_adr_o <= {r_adr[23:0], cmd_data};
              r_tmo_cnt <= 16'h0;
            end
          end
        end
        S_DATA: begin
          if (w_cmd_fire) begin
            r_dat      <= {r_dat[15:0], cmd_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_last_byte) begin
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_we_o  <= 1'b1;
              wbm_sel_o <= SEL_ALL;
              wbm_adr_o <= r_adr;
              wbm_dat_o <= {r_dat, cmd_data};
              r_tmo_cnt <= 16'h0;
            end
          end
        end
        S_BUS: begin
          if (w_bus_done) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'h1;
          end
        end
        default: ;
      endcase
    end
  end

  wb_rsp_serializer u_rsp (
    .clk         (wb_clk_i),
    .rst_n       (rst_n),
    .i_load      (w_ld),
    .i_status    (w_ld_status),
    .i_word      (w_ld_word),
    .i_has_word  (w_ld_has_word),
    .o_rsp_data  (rsp_data),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_done      (w_rsp_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_cmd_initiator: randomized self-checking bench for the Wishbone  |
// | command initiator. Revision: 1.0                                     |
// +----------------------------------------------------------------------+
module tb_wb_cmd_initiator;

  localparam int TMO = 4;

  logic        wb_clk_i;
  logic        rst_n;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        busy;

  wb_cmd_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i  (wb_clk_i),
    .rst_n     (rst_n),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .rsp_data  (rsp_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .busy      (busy)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  int tests_run = 0;
  int tests_failed = 0;

  // Slave behaviour, set by the tests
  int          ack_delay;
  logic        stray_ack;
  logic [31:0] slave_rdata;

  // Bus observations, written only by the slave/monitor process
  int          stb_cnt = 0;
  int          bus_count = 0;
  int          unstable_cnt = 0;
  int          mon_stb_cycles = 0;
  logic [31:0] mon_adr;
  logic [31:0] mon_dat;
  logic        mon_we;
  logic [3:0]  mon_sel;

  // Slave acks in stb cycle ack_delay+1 (counting from 1)
  always @(negedge wb_clk_i) begin
    wbm_dat_i = slave_rdata;
    if (wbm_stb_o && wbm_cyc_o) begin
      if (stb_cnt == 0) begin
        bus_count++;
        mon_adr = wbm_adr_o;
        mon_dat = wbm_dat_o;
        mon_we  = wbm_we_o;
        mon_sel = wbm_sel_o;
      end else if (wbm_adr_o !== mon_adr || wbm_dat_o !== mon_dat ||
                   wbm_we_o !== mon_we || wbm_sel_o !== mon_sel) begin
        unstable_cnt++;
      end
      wbm_ack_i = (stb_cnt == ack_delay);
      stb_cnt++;
      mon_stb_cycles = stb_cnt;
    end else begin
      if (wbm_stb_o !== wbm_cyc_o) unstable_cnt++;
      wbm_ack_i = stray_ack;
      stb_cnt   = 0;
    end
  end

  logic [7:0] rsp_q[$];
  int         rsp_t[$];
  logic [7:0] exp_q[$];
  int         exit_t;

  function automatic logic [47:0] pack_bytes(input logic [7:0] q[$]);
    logic [47:0] r;
    r = '0;
    r[47:40] = 8'(q.size());
    for (int i = 0; i < q.size() && i < 5; i++) r[39:0] = {r[31:0], q[i]};
    return r;
  endfunction

  // Reference: what the tester should see for one packet
  task automatic model_rsp(input logic [7:0] op, input int delay, input logic [31:0] rd);
    exp_q = {};
    if (op == 8'h57 || op == 8'h52) begin
      if (delay < TMO) begin
        exp_q.push_back(8'h4B);
        if (op == 8'h52) for (int i = 3; i >= 0; i--) exp_q.push_back(rd[8*i +: 8]);
      end else begin
        exp_q.push_back(8'h54);
      end
    end else if (op == 8'h4E) begin
      exp_q.push_back(8'h4B);
    end else begin
      exp_q.push_back(8'h3F);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge wb_clk_i);
    cmd_valid = 1'b1;
    cmd_data  = b;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge wb_clk_i);
      t++;
    end
    if (t >= 50) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_byte: cmd_ready stuck low, byte %h", b);
    end
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [31:0] adr,
                          input logic [31:0] dat, input bit gaps);
    send_byte(op, gaps);
    if (op == 8'h57 || op == 8'h52)
      for (int i = 3; i >= 0; i--) send_byte(adr[8*i +: 8], gaps);
    if (op == 8'h57)
      for (int i = 3; i >= 0; i--) send_byte(dat[8*i +: 8], gaps);
  endtask

  // t counts negedges from the call; a byte seen at t is taken at the next posedge
  task automatic collect_rsp(input bit rnd_ready);
    int t;
    rsp_q = {};
    rsp_t = {};
    t = 0;
    while ((busy || rsp_valid) && t < 300) begin
      rsp_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp_valid && rsp_ready) begin
        rsp_q.push_back(rsp_data);
        rsp_t.push_back(t);
      end
      @(negedge wb_clk_i);
      t++;
    end
    rsp_ready = 1'b0;
    exit_t = t;
    if (t >= 300) begin
      tests_run++;
      tests_failed++;
      $display("FAIL collect_rsp: busy never cleared");
    end
  endtask

  task automatic test_reset();
    logic [83:0] exp_v;
    exp_v = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0};
    repeat (3) @(negedge wb_clk_i);
    tests_run++;
    if ({cmd_ready, rsp_valid, rsp_data, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
         wbm_adr_o, wbm_dat_o, busy} !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_values: got %h expected %h",
               {cmd_ready, rsp_valid, rsp_data, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
                wbm_adr_o, wbm_dat_o, busy}, exp_v);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    tests_run++;
    if ({cmd_ready, rsp_valid, busy, wbm_stb_o} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL after_release: got %b expected 1000", {cmd_ready, rsp_valid, busy, wbm_stb_o});
    end
  endtask

  task automatic test_write();
    int b0, u0;
    b0 = bus_count; u0 = unstable_cnt;
    ack_delay = 2;
    slave_rdata = $urandom;
    send_pkt(8'h57, 32'h3000_0004, 32'hDEAD_BEEF, 1'b0);
    tests_run++;
    if ({wbm_cyc_o, wbm_stb_o} !== 2'b11) begin
      tests_failed++;
      $display("FAIL write_bus_start: got %b expected 11", {wbm_cyc_o, wbm_stb_o});
    end
    collect_rsp(1'b0);
    tests_run++;
    if ({mon_adr, mon_dat, mon_we, mon_sel} !== {32'h3000_0004, 32'hDEAD_BEEF, 1'b1, 4'hF}) begin
      tests_failed++;
      $display("FAIL write_bus_fields: got %h %h %b %h expected 30000004 deadbeef 1 f",
               mon_adr, mon_dat, mon_we, mon_sel);
    end
    tests_run++;
    if (mon_stb_cycles != 3 || bus_count - b0 != 1 || unstable_cnt != u0) begin
      tests_failed++;
      $display("FAIL write_stb: got cycles %0d cycles_started %0d unstable %0d expected 3 1 0",
               mon_stb_cycles, bus_count - b0, unstable_cnt - u0);
    end
    model_rsp(8'h57, 2, 32'h0);
    tests_run++;
    if (pack_bytes(rsp_q) !== pack_bytes(exp_q)) begin
      tests_failed++;
      $display("FAIL write_rsp: got %h expected %h", pack_bytes(rsp_q), pack_bytes(exp_q));
    end
  endtask

  task automatic test_read();
    ack_delay = 0;
    slave_rdata = 32'h1234_5678;
    send_pkt(8'h52, 32'h3000_0000, 32'h0, 1'b0);
    tests_run++;
    if ({wbm_stb_o, wbm_we_o, rsp_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL read_bus_start: got %b expected 100", {wbm_stb_o, wbm_we_o, rsp_valid});
    end
    collect_rsp(1'b0);
    model_rsp(8'h52, 0, 32'h1234_5678);
    tests_run++;
    if (pack_bytes(rsp_q) !== pack_bytes(exp_q) || mon_adr !== 32'h3000_0000 || mon_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_rsp: got %h adr %h we %b expected %h adr 30000000 we 0",
               pack_bytes(rsp_q), mon_adr, mon_we, pack_bytes(exp_q));
    end
    // Last command byte in cycle k, first response byte valid in cycle k+2
    tests_run++;
    if (rsp_t.size() != 5 || rsp_t[0] != 1 || rsp_t[4] != 5 || exit_t != 6) begin
      tests_failed++;
      $display("FAIL read_timing: got first %0d last %0d exit %0d expected 1 5 6",
               rsp_t.size() > 0 ? rsp_t[0] : -1, rsp_t.size() > 4 ? rsp_t[4] : -1, exit_t);
    end
    tests_run++;
    if (cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_next_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_timeout();
    ack_delay = 1000;
    send_pkt(8'h52, $urandom, 32'h0, 1'b0);
    collect_rsp(1'b0);
    tests_run++;
    if (mon_stb_cycles != TMO) begin
      tests_failed++;
      $display("FAIL timeout_stb_cycles: got %0d expected %0d", mon_stb_cycles, TMO);
    end
    model_rsp(8'h52, 1000, 32'h0);
    tests_run++;
    if (pack_bytes(rsp_q) !== pack_bytes(exp_q) || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_rsp: got %h busy %b expected %h busy 0",
               pack_bytes(rsp_q), busy, pack_bytes(exp_q));
    end
    // Ack arriving in the final allowed cycle beats the timeout
    ack_delay = TMO - 1;
    slave_rdata = $urandom;
    send_pkt(8'h52, $urandom, 32'h0, 1'b0);
    collect_rsp(1'b0);
    model_rsp(8'h52, TMO - 1, slave_rdata);
    tests_run++;
    if (pack_bytes(rsp_q) !== pack_bytes(exp_q) || mon_stb_cycles != TMO) begin
      tests_failed++;
      $display("FAIL ack_at_timeout: got %h cycles %0d expected %h cycles %0d",
               pack_bytes(rsp_q), mon_stb_cycles, pack_bytes(exp_q), TMO);
    end
  endtask

  task automatic test_badop_nop();
    int b0;
    b0 = bus_count;
    stray_ack = 1'b1;
    repeat (4) @(negedge wb_clk_i);
    stray_ack = 1'b0;
    @(negedge wb_clk_i);
    tests_run++;
    if ({busy, rsp_valid, cmd_ready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL stray_ack: got %b expected 001", {busy, rsp_valid, cmd_ready});
    end
    send_pkt(8'hAA, 32'h0, 32'h0, 1'b0);
    collect_rsp(1'b0);
    model_rsp(8'hAA, 0, 32'h0);
    tests_run++;
    if (pack_bytes(rsp_q) !== pack_bytes(exp_q)) begin
      tests_failed++;
      $display("FAIL badop_rsp: got %h expected %h", pack_bytes(rsp_q), pack_bytes(exp_q));
    end
    send_pkt(8'h4E, 32'h0, 32'h0, 1'b0);
    collect_rsp(1'b0);
    model_rsp(8'h4E, 0, 32'h0);
    tests_run++;
    if (pack_bytes(rsp_q) !== pack_bytes(exp_q)) begin
      tests_failed++;
      $display("FAIL nop_rsp: got %h expected %h", pack_bytes(rsp_q), pack_bytes(exp_q));
    end
    tests_run++;
    if (bus_count != b0) begin
      tests_failed++;
      $display("FAIL badop_nop_no_bus: got %0d cycles expected 0", bus_count - b0);
    end
  endtask

  task automatic test_backpressure();
    int t, bad;
    ack_delay = 0;
    slave_rdata = $urandom;
    send_pkt(8'h52, $urandom, 32'h0, 1'b0);
    t = 0;
    while (!rsp_valid && t < 20) begin
      @(negedge wb_clk_i);
      t++;
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 8'h4B || cmd_ready !== 1'b0) bad++;
      @(negedge wb_clk_i);
    end
    tests_run++;
    if (bad != 0 || t >= 20) begin
      tests_failed++;
      $display("FAIL backpressure_hold: got %0d bad cycles (wait %0d) expected 0", bad, t);
    end
    collect_rsp(1'b0);
    model_rsp(8'h52, 0, slave_rdata);
    tests_run++;
    if (pack_bytes(rsp_q) !== pack_bytes(exp_q)) begin
      tests_failed++;
      $display("FAIL backpressure_rsp: got %h expected %h", pack_bytes(rsp_q), pack_bytes(exp_q));
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    ack_delay = 1000;
    send_pkt(8'h52, $urandom, 32'h0, 1'b0);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({wbm_cyc_o, wbm_stb_o} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_mid_drop: got %b expected 00", {wbm_cyc_o, wbm_stb_o});
    end
    repeat (2) @(negedge wb_clk_i);
    rst_n = 1'b1;
    @(negedge wb_clk_i);
    tests_run++;
    if ({busy, cmd_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL reset_mid_idle: got %b expected 01", {busy, cmd_ready});
    end
    seen = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid || wbm_stb_o) seen++;
      @(negedge wb_clk_i);
    end
    rsp_ready = 1'b0;
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_silent: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_random();
    logic [7:0]  op;
    logic [31:0] adr, dat;
    int          dly, b0, u0, exp_cyc;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: op = 8'h57;
        1: op = 8'h52;
        2: op = 8'h4E;
        default: begin
          op = 8'($urandom_range(0, 255));
          while (op == 8'h57 || op == 8'h52 || op == 8'h4E) op = 8'($urandom_range(0, 255));
        end
      endcase
      adr = $urandom;
      dat = $urandom;
      dly = $urandom_range(0, 5);
      ack_delay = dly;
      slave_rdata = $urandom;
      b0 = bus_count;
      u0 = unstable_cnt;
      send_pkt(op, adr, dat, 1'b1);
      collect_rsp(1'b1);
      model_rsp(op, dly, slave_rdata);
      tests_run++;
      if (pack_bytes(rsp_q) !== pack_bytes(exp_q)) begin
        tests_failed++;
        $display("FAIL rand_rsp[%0d] op %h: got %h expected %h", n, op, pack_bytes(rsp_q), pack_bytes(exp_q));
      end
      if (op == 8'h57 || op == 8'h52) begin
        exp_cyc = (dly < TMO) ? dly + 1 : TMO;
        tests_run++;
        if (bus_count - b0 != 1 || mon_adr !== adr || mon_we !== (op == 8'h57) || mon_sel !== 4'hF ||
            (op == 8'h57 && mon_dat !== dat) || mon_stb_cycles != exp_cyc || unstable_cnt != u0) begin
          tests_failed++;
          $display("FAIL rand_bus[%0d]: got n %0d adr %h dat %h we %b cyc %0d expected 1 %h %h %b %0d",
                   n, bus_count - b0, mon_adr, mon_dat, mon_we, mon_stb_cycles,
                   adr, dat, op == 8'h57, exp_cyc);
        end
      end else begin
        tests_run++;
        if (bus_count != b0) begin
          tests_failed++;
          $display("FAIL rand_nobus[%0d]: got %0d cycles expected 0", n, bus_count - b0);
        end
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_data    = 8'h00;
    rsp_ready   = 1'b0;
    ack_delay   = 0;
    stray_ack   = 1'b0;
    slave_rdata = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_badop_nop();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
